// File: rtl/sram_port_scheduler_pkg.sv
// Shared definitions for the SRAM port scheduler: port IDs, write-field layout,
// tag encoding and default tag FIFO depth.
package sram_port_scheduler_pkg;

    localparam int TAG_DEPTH_DEFAULT = 8;

    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 32;
    localparam int MASK_W   = 4;
    localparam int WR_DIN_W = MASK_W + ADDR_W + DATA_W;

    // w*_din = {mask[3:0], addr[17:0], data[31:0]}
    localparam int WR_DATA_LSB = 0;
    localparam int WR_DATA_MSB = 31;
    localparam int WR_ADDR_LSB = 32;
    localparam int WR_ADDR_MSB = 49;
    localparam int WR_MASK_LSB = 50;
    localparam int WR_MASK_MSB = 53;

    typedef enum logic [1:0] {
        PORT_W0 = 2'd0,
        PORT_R0 = 2'd1,
        PORT_W1 = 2'd2,
        PORT_R1 = 2'd3
    } port_id_e;

    localparam logic TAG_R0 = 1'b0;
    localparam logic TAG_R1 = 1'b1;

endpackage

// File: rtl/sram_tag_fifo.sv
// 1-bit tag FIFO recording which read port owns each outstanding SRAM read.
// Accepts a push while full when a pop happens in the same cycle.
module sram_tag_fifo #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             wr_data,
    input  logic             pop,
    output logic             rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sram_port_scheduler.sv
// Arbitrates two write and two read ports onto a single registered SRAM command,
// and routes in-order read returns back to the issuing read port via a tag FIFO.
module sram_port_scheduler
    import sram_port_scheduler_pkg::*;
#(
    parameter int TAG_DEPTH = TAG_DEPTH_DEFAULT,
    parameter int MAX_BURST = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                w0_din_valid,
    output logic                w0_din_ready,
    input  logic [WR_DIN_W-1:0] w0_din,
    input  logic                w1_din_valid,
    output logic                w1_din_ready,
    input  logic [WR_DIN_W-1:0] w1_din,
    input  logic                r0_din_valid,
    output logic                r0_din_ready,
    input  logic [ADDR_W-1:0]   r0_din,
    output logic                r0_dout_valid,
    output logic [DATA_W-1:0]   r0_dout,
    input  logic                r1_din_valid,
    output logic                r1_din_ready,
    input  logic [ADDR_W-1:0]   r1_din,
    output logic                r1_dout_valid,
    output logic [DATA_W-1:0]   r1_dout,
    output logic                sram_addr_valid,
    input  logic                sram_ready,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_data_in,
    output logic [MASK_W-1:0]   sram_write_mask,
    input  logic [DATA_W-1:0]   sram_data_out,
    input  logic                sram_data_out_valid,
    output logic [4:0]          reads_outstanding,
    output logic                return_error
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int CNT_W   = $clog2(TAG_DEPTH) + 1;

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] b);
        return (b >= BURST_W'(MAX_BURST)) ? b : b + 1'b1;
    endfunction

    logic                cmd_vld_q, cmd_vld_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
    logic [MASK_W-1:0]   cmd_mask_q, cmd_mask_d;
    logic [1:0]          last_q, last_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                r0_dout_valid_q, r0_dout_valid_d;
    logic                r1_dout_valid_q, r1_dout_valid_d;
    logic [DATA_W-1:0]   r0_dout_q, r0_dout_d;
    logic [DATA_W-1:0]   r1_dout_q, r1_dout_d;
    logic                return_error_q, return_error_d;

    logic                fifo_full, fifo_empty, fifo_rd_tag;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_push, fifo_pop, fifo_wr_tag;
    logic                free, rd_ok, others_req, grant_vld;
    logic [3:0]          req;
    logic [1:0]          grant_id, start, cand;

    // Arbitration: sticky burst priority, then round-robin from the port after last_q.
    always_comb begin
        free       = ~cmd_vld_q | sram_ready;
        fifo_pop   = sram_data_out_valid & ~fifo_empty;
        rd_ok      = ~fifo_full | fifo_pop;
        req        = {r1_din_valid & rd_ok, w1_din_valid, r0_din_valid & rd_ok, w0_din_valid};
        others_req = |(req & ~(4'b0001 << last_q));
        grant_vld  = 1'b0;
        grant_id   = last_q;
        start      = (burst_q == '0) ? last_q : last_q + 2'd1;
        cand       = start;
        if (free && !reset) begin
            if (burst_q != '0 && req[last_q] &&
                !(burst_q >= BURST_W'(MAX_BURST) && others_req)) begin
                grant_vld = 1'b1;
                grant_id  = last_q;
            end else begin
                for (int i = 3; i >= 0; i--) begin
                    cand = start + 2'(i);
                    if (req[cand]) begin
                        grant_vld = 1'b1;
                        grant_id  = cand;
                    end
                end
            end
        end
    end

    assign w0_din_ready = grant_vld && (grant_id == PORT_W0);
    assign r0_din_ready = grant_vld && (grant_id == PORT_R0);
    assign w1_din_ready = grant_vld && (grant_id == PORT_W1);
    assign r1_din_ready = grant_vld && (grant_id == PORT_R1);

    assign fifo_push   = r0_din_ready | r1_din_ready;
    assign fifo_wr_tag = r1_din_ready ? TAG_R1 : TAG_R0;

    always_comb begin
        cmd_vld_d  = cmd_vld_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_mask_d = cmd_mask_q;
        last_d     = last_q;
        burst_d    = burst_q;
        if (free) begin
            cmd_vld_d = grant_vld;
        end
        if (grant_vld) begin
            case (grant_id)
                PORT_W0: begin
                    cmd_addr_d = w0_din[WR_ADDR_MSB:WR_ADDR_LSB];
                    cmd_data_d = w0_din[WR_DATA_MSB:WR_DATA_LSB];
                    cmd_mask_d = w0_din[WR_MASK_MSB:WR_MASK_LSB];
                end
                PORT_W1: begin
                    cmd_addr_d = w1_din[WR_ADDR_MSB:WR_ADDR_LSB];
                    cmd_data_d = w1_din[WR_DATA_MSB:WR_DATA_LSB];
                    cmd_mask_d = w1_din[WR_MASK_MSB:WR_MASK_LSB];
                end
                PORT_R0: begin
                    cmd_addr_d = r0_din;
                    cmd_data_d = '0;
                    cmd_mask_d = '0;
                end
                default: begin
                    cmd_addr_d = r1_din;
                    cmd_data_d = '0;
                    cmd_mask_d = '0;
                end
            endcase
            last_d = grant_id;
            // Repeat grants only count toward the limit while someone else is waiting.
            if (burst_q != '0 && grant_id == last_q) begin
                burst_d = others_req ? sat_inc(burst_q) : BURST_W'(1);
            end else begin
                burst_d = BURST_W'(1);
            end
        end
    end

    always_comb begin
        r0_dout_valid_d = fifo_pop & (fifo_rd_tag == TAG_R0);
        r1_dout_valid_d = fifo_pop & (fifo_rd_tag == TAG_R1);
        r0_dout_d       = r0_dout_valid_d ? sram_data_out : r0_dout_q;
        r1_dout_d       = r1_dout_valid_d ? sram_data_out : r1_dout_q;
        return_error_d  = return_error_q | (sram_data_out_valid & fifo_empty);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_vld_q       <= 1'b0;
            cmd_addr_q      <= '0;
            cmd_data_q      <= '0;
            cmd_mask_q      <= '0;
            last_q          <= PORT_W0;
            burst_q         <= '0;
            r0_dout_valid_q <= 1'b0;
            r1_dout_valid_q <= 1'b0;
            r0_dout_q       <= '0;
            r1_dout_q       <= '0;
            return_error_q  <= 1'b0;
        end else begin
            cmd_vld_q       <= cmd_vld_d;
            cmd_addr_q      <= cmd_addr_d;
            cmd_data_q      <= cmd_data_d;
            cmd_mask_q      <= cmd_mask_d;
            last_q          <= last_d;
            burst_q         <= burst_d;
            r0_dout_valid_q <= r0_dout_valid_d;
            r1_dout_valid_q <= r1_dout_valid_d;
            r0_dout_q       <= r0_dout_d;
            r1_dout_q       <= r1_dout_d;
            return_error_q  <= return_error_d;
        end
    end

    sram_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (fifo_wr_tag),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_tag),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign sram_addr_valid   = cmd_vld_q;
    assign sram_addr         = cmd_addr_q;
    assign sram_data_in      = cmd_data_q;
    assign sram_write_mask   = cmd_mask_q;
    assign r0_dout_valid     = r0_dout_valid_q;
    assign r1_dout_valid     = r1_dout_valid_q;
    assign r0_dout           = r0_dout_q;
    assign r1_dout           = r1_dout_q;
    assign reads_outstanding = 5'(fifo_count);
    assign return_error      = return_error_q;

endmodule

// File: tb/tb_sram_port_scheduler.sv
// Directed testbench for sram_port_scheduler: reset, single/masked writes,
// stall under backpressure, burst limit, round-robin share, tag FIFO full and return routing.
module tb_sram_port_scheduler;
    import sram_port_scheduler_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        w0_din_valid, w0_din_ready;
    logic [53:0] w0_din;
    logic        w1_din_valid, w1_din_ready;
    logic [53:0] w1_din;
    logic        r0_din_valid, r0_din_ready;
    logic [17:0] r0_din;
    logic        r0_dout_valid;
    logic [31:0] r0_dout;
    logic        r1_din_valid, r1_din_ready;
    logic [17:0] r1_din;
    logic        r1_dout_valid;
    logic [31:0] r1_dout;
    logic        sram_addr_valid, sram_ready;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out;
    logic        sram_data_out_valid;
    logic [4:0]  reads_outstanding;
    logic        return_error;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    sram_port_scheduler #(.TAG_DEPTH(8), .MAX_BURST(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .w0_din_valid        (w0_din_valid),
        .w0_din_ready        (w0_din_ready),
        .w0_din              (w0_din),
        .w1_din_valid        (w1_din_valid),
        .w1_din_ready        (w1_din_ready),
        .w1_din              (w1_din),
        .r0_din_valid        (r0_din_valid),
        .r0_din_ready        (r0_din_ready),
        .r0_din              (r0_din),
        .r0_dout_valid       (r0_dout_valid),
        .r0_dout             (r0_dout),
        .r1_din_valid        (r1_din_valid),
        .r1_din_ready        (r1_din_ready),
        .r1_din              (r1_din),
        .r1_dout_valid       (r1_dout_valid),
        .r1_dout             (r1_dout),
        .sram_addr_valid     (sram_addr_valid),
        .sram_ready          (sram_ready),
        .sram_addr           (sram_addr),
        .sram_data_in        (sram_data_in),
        .sram_write_mask     (sram_write_mask),
        .sram_data_out       (sram_data_out),
        .sram_data_out_valid (sram_data_out_valid),
        .reads_outstanding   (reads_outstanding),
        .return_error        (return_error)
    );

    function automatic logic [3:0] readys();
        return {r1_din_ready, w1_din_ready, r0_din_ready, w0_din_ready};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        w0_din_valid = 1'b0; w0_din = '0;
        w1_din_valid = 1'b0; w1_din = '0;
        r0_din_valid = 1'b0; r0_din = '0;
        r1_din_valid = 1'b0; r1_din = '0;
        sram_ready = 1'b1;
        sram_data_out_valid = 1'b0;
        sram_data_out = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        w0_din_valid = 1'b1; r0_din_valid = 1'b1; w1_din_valid = 1'b1; r1_din_valid = 1'b1;
        sram_data_out_valid = 1'b1;
        cyc(); cyc(); settle();
        n_cmp++; if (readys() !== 4'b0000) begin n_bad++; $display("FAIL reset_readys: got %b expected 0000", readys()); end
        n_cmp++; if (sram_addr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_addr_valid: got %b expected 0", sram_addr_valid); end
        n_cmp++; if ({sram_addr, sram_data_in, sram_write_mask} !== 54'd0) begin n_bad++; $display("FAIL reset_cmd_fields: got %h expected 0", {sram_addr, sram_data_in, sram_write_mask}); end
        n_cmp++; if (reads_outstanding !== 5'd0) begin n_bad++; $display("FAIL reset_outstanding: got %0d expected 0", reads_outstanding); end
        n_cmp++; if (return_error !== 1'b0) begin n_bad++; $display("FAIL reset_return_error: got %b expected 0", return_error); end
        n_cmp++; if ({r0_dout_valid, r1_dout_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_dout_valid: got %b expected 00", {r0_dout_valid, r1_dout_valid}); end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        cyc();
        w0_din_valid = 1'b1; w0_din = {4'hF, 18'h00010, 32'hDEADBEEF};
        settle();
        n_cmp++; if (readys() !== 4'b0001) begin n_bad++; $display("FAIL w0_grant: got %b expected 0001", readys()); end
        cyc();
        w0_din_valid = 1'b0; w0_din = '0;
        settle();
        n_cmp++; if (sram_addr_valid !== 1'b1) begin n_bad++; $display("FAIL w0_cmd_valid: got %b expected 1", sram_addr_valid); end
        n_cmp++; if (sram_addr !== 18'h00010) begin n_bad++; $display("FAIL w0_cmd_addr: got %h expected 00010", sram_addr); end
        n_cmp++; if (sram_write_mask !== 4'hF) begin n_bad++; $display("FAIL w0_cmd_mask: got %h expected f", sram_write_mask); end
        n_cmp++; if (sram_data_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL w0_cmd_data: got %h expected deadbeef", sram_data_in); end
        cyc(); settle();
        n_cmp++; if (sram_addr_valid !== 1'b0) begin n_bad++; $display("FAIL w0_cmd_drain: got %b expected 0", sram_addr_valid); end
        w1_din_valid = 1'b1; w1_din = {4'h0, 18'h2ABCD, 32'h12345678};
        settle();
        n_cmp++; if (readys() !== 4'b0100) begin n_bad++; $display("FAIL w1_grant: got %b expected 0100", readys()); end
        cyc();
        w1_din_valid = 1'b0;
        settle();
        n_cmp++; if ({sram_addr_valid, sram_addr, sram_write_mask, sram_data_in} !== {1'b1, 18'h2ABCD, 4'h0, 32'h12345678}) begin
            n_bad++; $display("FAIL w1_zero_mask_cmd: got %h expected %h", {sram_addr_valid, sram_addr, sram_write_mask, sram_data_in}, {1'b1, 18'h2ABCD, 4'h0, 32'h12345678});
        end
    endtask

    task automatic test_ready_low();
        do_reset();
        cyc();
        sram_ready = 1'b0;
        w0_din_valid = 1'b1; w0_din = {4'hA, 18'h00003, 32'h00000055};
        settle();
        n_cmp++; if (readys() !== 4'b0001) begin n_bad++; $display("FAIL stall_first_grant: got %b expected 0001", readys()); end
        cyc();
        w0_din_valid = 1'b0;
        w1_din_valid = 1'b1; w1_din = {4'h5, 18'h00004, 32'h00000066};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            settle();
            n_cmp++; if ({sram_addr_valid, sram_addr, sram_write_mask, sram_data_in} !== {1'b1, 18'h00003, 4'hA, 32'h00000055}) begin
                n_bad++; $display("FAIL stall_cmd_stable_%0d: got %h expected %h", i, {sram_addr_valid, sram_addr, sram_write_mask, sram_data_in}, {1'b1, 18'h00003, 4'hA, 32'h00000055});
            end
            n_cmp++; if (readys() !== 4'b0000) begin n_bad++; $display("FAIL stall_no_ready_%0d: got %b expected 0000", i, readys()); end
        end
        cyc();
        sram_ready = 1'b1;
        settle();
        n_cmp++; if (readys() !== 4'b0100) begin n_bad++; $display("FAIL stall_release_grant: got %b expected 0100", readys()); end
        cyc();
        w1_din_valid = 1'b0;
        settle();
        n_cmp++; if ({sram_addr_valid, sram_addr, sram_write_mask, sram_data_in} !== {1'b1, 18'h00004, 4'h5, 32'h00000066}) begin
            n_bad++; $display("FAIL stall_next_cmd: got %h expected %h", {sram_addr_valid, sram_addr, sram_write_mask, sram_data_in}, {1'b1, 18'h00004, 4'h5, 32'h00000066});
        end
        cyc(); settle();
        n_cmp++; if (sram_addr_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drain: got %b expected 0", sram_addr_valid); end
    endtask

    task automatic test_burst_limit();
        do_reset();
        cyc();
        w0_din_valid = 1'b1; w0_din = {4'h3, 18'h00020, 32'hA5A5A5A5};
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc();
            settle();
            n_cmp++; if (readys() !== 4'b0001) begin n_bad++; $display("FAIL burst_alone_%0d: got %b expected 0001", i, readys()); end
        end
        cyc();
        r1_din_valid = 1'b1; r1_din = 18'h3FFFF;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) cyc();
            settle();
            n_cmp++; if (readys() !== 4'b0001) begin n_bad++; $display("FAIL burst_w0_keeps_%0d: got %b expected 0001", j, readys()); end
        end
        cyc(); settle();
        n_cmp++; if (readys() !== 4'b1000) begin n_bad++; $display("FAIL burst_switch_r1: got %b expected 1000", readys()); end
        cyc(); settle();
        n_cmp++; if (readys() !== 4'b1000) begin n_bad++; $display("FAIL burst_r1_keeps: got %b expected 1000", readys()); end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int cnt [4];
        logic [3:0] got;
        logic [3:0] exp_bits;
        do_reset();
        cyc();
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        w0_din_valid = 1'b1; w0_din = {4'h1, 18'h00100, 32'h11111111};
        r0_din_valid = 1'b1; r0_din = 18'h00200;
        w1_din_valid = 1'b1; w1_din = {4'h2, 18'h00300, 32'h22222222};
        r1_din_valid = 1'b1; r1_din = 18'h00400;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) cyc();
            settle();
            got = readys();
            exp_bits = 4'b0001 << (k / 4);
            n_cmp++; if (got !== exp_bits) begin n_bad++; $display("FAIL rr_grant_%0d: got %b expected %b", k, got, exp_bits); end
            for (int p = 0; p < 4; p++) if (got[p]) cnt[p]++;
        end
        for (int p = 0; p < 4; p++) begin
            n_cmp++; if (cnt[p] !== 4) begin n_bad++; $display("FAIL rr_share_port%0d: got %0d expected 4", p, cnt[p]); end
        end
        cyc();
        idle_inputs();
        settle();
        n_cmp++; if (reads_outstanding !== 5'd8) begin n_bad++; $display("FAIL rr_outstanding: got %0d expected 8", reads_outstanding); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        cyc();
        r0_din_valid = 1'b1; r0_din = 18'h00100;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            settle();
            n_cmp++; if (r0_din_ready !== 1'b1) begin n_bad++; $display("FAIL full_issue_%0d: got %b expected 1", i, r0_din_ready); end
        end
        cyc(); settle();
        n_cmp++; if (r0_din_ready !== 1'b0) begin n_bad++; $display("FAIL full_ninth_stalls: got %b expected 0", r0_din_ready); end
        n_cmp++; if (reads_outstanding !== 5'd8) begin n_bad++; $display("FAIL full_count: got %0d expected 8", reads_outstanding); end
        cyc(); settle();
        n_cmp++; if (r0_din_ready !== 1'b0) begin n_bad++; $display("FAIL full_still_stalled: got %b expected 0", r0_din_ready); end
        cyc();
        sram_data_out_valid = 1'b1; sram_data_out = 32'hCAFE0001;
        settle();
        n_cmp++; if (r0_din_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_frees: got %b expected 1", r0_din_ready); end
        cyc();
        sram_data_out_valid = 1'b0; r0_din_valid = 1'b0;
        settle();
        n_cmp++; if (reads_outstanding !== 5'd8) begin n_bad++; $display("FAIL full_push_pop_count: got %0d expected 8", reads_outstanding); end
        n_cmp++; if ({r0_dout_valid, r1_dout_valid, r0_dout} !== {2'b10, 32'hCAFE0001}) begin
            n_bad++; $display("FAIL full_return_r0: got %h expected %h", {r0_dout_valid, r1_dout_valid, r0_dout}, {2'b10, 32'hCAFE0001});
        end
        cyc(); settle();
        n_cmp++; if (r0_dout_valid !== 1'b0) begin n_bad++; $display("FAIL full_return_one_cycle: got %b expected 0", r0_dout_valid); end
    endtask

    task automatic test_return_order();
        do_reset();
        cyc();
        r0_din_valid = 1'b1; r0_din = 18'h00011;
        settle();
        n_cmp++; if (readys() !== 4'b0010) begin n_bad++; $display("FAIL ord_issue_r0a: got %b expected 0010", readys()); end
        cyc();
        r0_din_valid = 1'b0; r1_din_valid = 1'b1; r1_din = 18'h00022;
        settle();
        n_cmp++; if (readys() !== 4'b1000) begin n_bad++; $display("FAIL ord_issue_r1: got %b expected 1000", readys()); end
        cyc();
        r1_din_valid = 1'b0; r0_din_valid = 1'b1; r0_din = 18'h00033;
        settle();
        n_cmp++; if (readys() !== 4'b0010) begin n_bad++; $display("FAIL ord_issue_r0b: got %b expected 0010", readys()); end
        cyc();
        r0_din_valid = 1'b0;
        settle();
        n_cmp++; if (reads_outstanding !== 5'd3) begin n_bad++; $display("FAIL ord_outstanding: got %0d expected 3", reads_outstanding); end
        sram_data_out_valid = 1'b1; sram_data_out = 32'h1;
        cyc();
        sram_data_out = 32'h2;
        settle();
        n_cmp++; if ({r0_dout_valid, r1_dout_valid, r0_dout} !== {2'b10, 32'h1}) begin n_bad++; $display("FAIL ord_ret1: got %h expected %h", {r0_dout_valid, r1_dout_valid, r0_dout}, {2'b10, 32'h1}); end
        cyc();
        sram_data_out = 32'h3;
        settle();
        n_cmp++; if ({r0_dout_valid, r1_dout_valid, r1_dout} !== {2'b01, 32'h2}) begin n_bad++; $display("FAIL ord_ret2: got %h expected %h", {r0_dout_valid, r1_dout_valid, r1_dout}, {2'b01, 32'h2}); end
        cyc();
        sram_data_out_valid = 1'b0;
        settle();
        n_cmp++; if ({r0_dout_valid, r1_dout_valid, r0_dout} !== {2'b10, 32'h3}) begin n_bad++; $display("FAIL ord_ret3: got %h expected %h", {r0_dout_valid, r1_dout_valid, r0_dout}, {2'b10, 32'h3}); end
        cyc(); settle();
        n_cmp++; if ({r0_dout_valid, r1_dout_valid, reads_outstanding, return_error} !== {2'b00, 5'd0, 1'b0}) begin
            n_bad++; $display("FAIL ord_idle: got %h expected %h", {r0_dout_valid, r1_dout_valid, reads_outstanding, return_error}, {2'b00, 5'd0, 1'b0});
        end
    endtask

    task automatic test_return_error();
        do_reset();
        cyc();
        sram_data_out_valid = 1'b1; sram_data_out = 32'h77;
        cyc();
        sram_data_out_valid = 1'b0;
        settle();
        n_cmp++; if (return_error !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b expected 1", return_error); end
        n_cmp++; if ({r0_dout_valid, r1_dout_valid} !== 2'b00) begin n_bad++; $display("FAIL err_no_dout: got %b expected 00", {r0_dout_valid, r1_dout_valid}); end
        n_cmp++; if (reads_outstanding !== 5'd0) begin n_bad++; $display("FAIL err_fifo_unchanged: got %0d expected 0", reads_outstanding); end
        cyc(); cyc(); cyc(); settle();
        n_cmp++; if (return_error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b expected 1", return_error); end
        do_reset();
        settle();
        n_cmp++; if (return_error !== 1'b0) begin n_bad++; $display("FAIL err_cleared_by_reset: got %b expected 0", return_error); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_ready_low();
        test_burst_limit();
        test_round_robin();
        test_fifo_full();
        test_return_order();
        test_return_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
